// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions the raw push-buttons feeding the stopwatch controller. Each of
// the N channels passes through a two-flop synchronizer and a stable-time
// filter. The filtered level only flips after the synchronized input has
// disagreed with it for STABLE_CYCLES consecutive cycles. The block also
// reports every debounced press as a single command strobe carrying the index
// of the lowest-numbered channel pressed in that cycle.
//
// Parameters:
//   N             number of button channels (1..8)
//   STABLE_CYCLES consecutive disagreeing cycles needed to flip a level (>= 1)
//   CNT_W         debounce counter width, 2**CNT_W >= STABLE_CYCLES
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn          raw asynchronous button levels, 1 = pressed
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
//   cmd_valid    one-cycle strobe, at least one press this cycle
//   cmd_idx      lowest pressed channel index; holds while cmd_valid is 0
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release,
   output logic         cmd_valid,
   output logic [2:0]   cmd_idx
);

   // Terminal count: the cycle on which the counter reaches this value while
   // still disagreeing is the STABLE_CYCLES-th consecutive disagreeing cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [N-1:0] sync1_reg;
   logic [N-1:0] sync2_reg;
   logic [N-1:0] level_reg;
   logic [N-1:0] press_reg;
   logic [N-1:0] release_reg;

   logic [N-1:0] level_next;
   logic [N-1:0] press_next;
   logic [N-1:0] release_next;

   logic         cmd_valid_reg;
   logic         cmd_valid_next;
   logic [2:0]   cmd_idx_reg;
   logic [2:0]   cmd_idx_next;

   // Per-channel stable-time filter. The counter only runs while the
   // synchronized input disagrees with the debounced level; any agreement
   // (a bounce back) clears it, so only an unbroken run can flip the level.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             differs;
         logic             expired;

         assign differs = (sync2_reg[gi] != level_reg[gi]);
         assign expired = differs && (cnt_reg == CNT_LAST);

         // Cleared both on agreement and on the flip itself, so the counter
         // never exceeds CNT_LAST and cannot wrap.
         assign cnt_next = (differs && !expired) ? cnt_reg + CNT_W'(1) : '0;

         assign level_next[gi]   = expired ? sync2_reg[gi] : level_reg[gi];
         assign press_next[gi]   = expired &  sync2_reg[gi];
         assign release_next[gi] = expired & ~sync2_reg[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
      end
   endgenerate

   // Priority encoder over the presses being registered this cycle; scanning
   // from the top down lets the lowest index overwrite the others.
   always_comb begin
      cmd_valid_next = |press_next;
      cmd_idx_next   = cmd_idx_reg;
      for (int i = N - 1; i >= 0; i--) begin
         if (press_next[i]) begin
            cmd_idx_next = 3'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         level_reg     <= '0;
         press_reg     <= '0;
         release_reg   <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_idx_reg   <= 3'd0;
      end else begin
         sync1_reg     <= btn;
         sync2_reg     <= sync1_reg;
         level_reg     <= level_next;
         press_reg     <= press_next;
         release_reg   <= release_next;
         cmd_valid_reg <= cmd_valid_next;
         cmd_idx_reg   <= cmd_idx_next;
      end
   end

   assign btn_level   = level_reg;
   assign btn_press   = press_reg;
   assign btn_release = release_reg;
   assign cmd_valid   = cmd_valid_reg;
   assign cmd_idx     = cmd_idx_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Self-checking bench for btn_debounce with N=4, STABLE_CYCLES=8. A directed
// vector table covers reset, a clean press and its release. Hand-written
// sequences cover bounce, glitch, simultaneous press, release and reset in the
// middle of a count. A randomized phase runs against a history-based model:
// a level flips on the edge where the last STABLE_CYCLES synchronized samples
// all differ from it and no flip or reset happened within that window.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

   localparam int N    = 4;
   localparam int S    = 8;
   localparam int CW   = 16;
   localparam int HMAX = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic         cmd_valid;
   logic [2:0]   cmd_idx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   btn_debounce #(
      .N             (N),
      .STABLE_CYCLES (S),
      .CNT_W         (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .cmd_valid   (cmd_valid),
      .cmd_idx     (cmd_idx)
   );

   // ---------------- reference model state ----------------
   logic [N-1:0] btn_h [HMAX];
   logic         rst_h [HMAX];
   int           t = 0;
   int           last_evt [N];
   logic [N-1:0] m_level = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_rel   = '0;
   logic         m_valid = 1'b0;
   logic [2:0]   m_idx   = 3'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronized value the filter evaluates on edge u: the button sampled two
   // edges earlier, unless a reset on either of the last two edges cleared it.
   function automatic logic [N-1:0] seen(input int u);
      if (u < 2) return '0;
      if (rst_h[u-1] || rst_h[u-2]) return '0;
      return btn_h[u-2];
   endfunction

   task automatic model_edge(input logic r, input logic [N-1:0] b);
      logic         all_diff;
      logic [N-1:0] s;
      if (t >= HMAX) begin
         $display("FAIL history: bench exceeded %0d edges", HMAX);
         $fatal(1);
      end
      btn_h[t] = b;
      rst_h[t] = r;
      m_press  = '0;
      m_rel    = '0;
      if (r) begin
         m_level = '0;
         m_valid = 1'b0;
         m_idx   = 3'd0;
         for (int i = 0; i < N; i++) last_evt[i] = t;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (t - last_evt[i] >= S) begin
               all_diff = 1'b1;
               for (int k = 0; k < S; k++) begin
                  s = seen(t - k);
                  if (s[i] == m_level[i]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  if (m_level[i]) m_rel[i] = 1'b1;
                  else            m_press[i] = 1'b1;
                  m_level[i]  = ~m_level[i];
                  last_evt[i] = t;
               end
            end
         end
         m_valid = |m_press;
         for (int i = N - 1; i >= 0; i--) begin
            if (m_press[i]) m_idx = 3'(i);
         end
      end
      t++;
   endtask

   // One clock: drive at the falling edge, let the rising edge happen, then
   // compare on the next falling edge.
   task automatic step(input logic r, input logic [N-1:0] b);
      rst = r;
      btn = b;
      model_edge(r, b);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("model_level@%0d", t), 32'(btn_level), 32'(m_level));
      check($sformatf("model_press@%0d", t), 32'(btn_press), 32'(m_press));
      check($sformatf("model_release@%0d", t), 32'(btn_release), 32'(m_rel));
      check($sformatf("model_valid@%0d", t), 32'(cmd_valid), 32'(m_valid));
      check($sformatf("model_idx@%0d", t), 32'(cmd_idx), 32'(m_idx));
   endtask

   // Holds b until a press (want_rel=0) or release (want_rel=1) pulse shows;
   // n is the number of clocks including the one that showed it, -1 on timeout.
   task automatic run_until(input logic [N-1:0] b, input logic want_rel, input int limit,
                            output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         step(1'b0, b);
         if ((want_rel ? btn_release : btn_press) != '0) begin
            n = k;
            break;
         end
      end
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] btn;
      logic [N-1:0] level;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic         valid;
      logic [2:0]   idx;
   } vec_t;

   vec_t vecs [26];

   initial begin
      int           n;
      logic [N-1:0] bad;
      logic [N-1:0] rb;
      int           len;

      rst = 1'b1;
      btn = '0;

      // Clean press of ch0 sampled at edge 1: level/press at edge 1+S+1=10.
      // Release sampled at edge 15: release pulse at edge 24.
      for (int j = 0; j < 26; j++) begin
         vecs[j].rst   = (j == 0);
         vecs[j].btn   = (j >= 1 && j < 15) ? 4'b0001 : 4'b0000;
         vecs[j].level = (j >= 10 && j < 24) ? 4'b0001 : 4'b0000;
         vecs[j].press = (j == 10) ? 4'b0001 : 4'b0000;
         vecs[j].rel   = (j == 24) ? 4'b0001 : 4'b0000;
         vecs[j].valid = (j == 10);
         vecs[j].idx   = 3'd0;
      end

      @(negedge clk);
      for (int j = 0; j < 26; j++) begin
         step(vecs[j].rst, vecs[j].btn);
         $display("vec %0d rst=%0b btn=%b level=%b press=%b release=%b valid=%0b idx=%0d",
                  j, vecs[j].rst, vecs[j].btn, btn_level, btn_press, btn_release, cmd_valid, cmd_idx);
         check($sformatf("vec%0d_level", j), 32'(btn_level), 32'(vecs[j].level));
         check($sformatf("vec%0d_press", j), 32'(btn_press), 32'(vecs[j].press));
         check($sformatf("vec%0d_release", j), 32'(btn_release), 32'(vecs[j].rel));
         check($sformatf("vec%0d_valid", j), 32'(cmd_valid), 32'(vecs[j].valid));
         check($sformatf("vec%0d_idx", j), 32'(cmd_idx), 32'(vecs[j].idx));
      end

      // Bounce on ch2: 3 high, 3 low, 3 high, 3 low, then held high.
      bad = '0;
      for (int rep = 0; rep < 2; rep++) begin
         repeat (3) begin step(1'b0, 4'b0100); bad |= btn_press | btn_level; end
         repeat (3) begin step(1'b0, 4'b0000); bad |= btn_press | btn_level; end
      end
      check("bounce_quiet", 32'(bad), 32'd0);
      run_until(4'b0100, 1'b0, 30, n);
      $display("bounce: press after %0d clocks press=%b valid=%0b idx=%0d", n, btn_press, cmd_valid, cmd_idx);
      check("bounce_latency", 32'(n), 32'(S + 2));
      check("bounce_press", 32'(btn_press), 32'b0100);
      check("bounce_valid", 32'(cmd_valid), 32'd1);
      check("bounce_idx", 32'(cmd_idx), 32'd2);
      bad = '0;
      repeat (12) begin step(1'b0, 4'b0100); bad |= btn_press; end
      check("held_no_repeat", 32'(bad), 32'd0);
      check("held_level", 32'(btn_level), 32'b0100);
      run_until(4'b0000, 1'b1, 30, n);
      check("bounce_release_latency", 32'(n), 32'(S + 2));

      // Glitch on ch1 shorter than the threshold.
      bad = '0;
      repeat (5)  begin step(1'b0, 4'b0010); bad |= btn_level | btn_press | {3'b000, cmd_valid}; end
      repeat (15) begin step(1'b0, 4'b0000); bad |= btn_level | btn_press | {3'b000, cmd_valid}; end
      $display("glitch: activity=%b", bad);
      check("glitch_quiet", 32'(bad), 32'd0);

      // Simultaneous press of ch1 and ch3.
      run_until(4'b1010, 1'b0, 30, n);
      $display("simul: press after %0d clocks press=%b valid=%0b idx=%0d", n, btn_press, cmd_valid, cmd_idx);
      check("simul_latency", 32'(n), 32'(S + 2));
      check("simul_press", 32'(btn_press), 32'b1010);
      check("simul_valid", 32'(cmd_valid), 32'd1);
      check("simul_idx", 32'(cmd_idx), 32'd1);
      step(1'b0, 4'b1010);
      check("simul_valid_next", 32'(cmd_valid), 32'd0);
      check("simul_press_next", 32'(btn_press), 32'd0);
      check("simul_idx_held", 32'(cmd_idx), 32'd1);

      // Release ch3 while ch1 stays held.
      bad = '0;
      n   = -1;
      for (int k = 1; k <= 30; k++) begin
         step(1'b0, 4'b0010);
         bad |= {3'b000, cmd_valid} | btn_press;
         if (btn_release != '0) begin
            n = k;
            break;
         end
      end
      $display("release: pulse after %0d clocks release=%b level=%b", n, btn_release, btn_level);
      check("release_latency", 32'(n), 32'(S + 2));
      check("release_pulse", 32'(btn_release), 32'b1000);
      check("release_level", 32'(btn_level), 32'b0010);
      check("release_no_cmd", 32'(bad), 32'd0);
      repeat (12) step(1'b0, 4'b0000);

      // Reset in the middle of a count on ch0.
      repeat (7) step(1'b0, 4'b0001);
      step(1'b1, 4'b0001);
      check("midrst_outputs", 32'({btn_level, btn_press, btn_release, cmd_valid, cmd_idx}), 32'd0);
      run_until(4'b0001, 1'b0, 30, n);
      $display("midrst: press after %0d clocks", n);
      check("midrst_latency", 32'(n), 32'(S + 2));
      repeat (12) step(1'b0, 4'b0000);

      // Randomized bursts against the reference model.
      for (int b = 0; b < 300; b++) begin
         rb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            step(1'b1, rb);
            $display("rand %0d: reset btn=%b", b, rb);
         end else begin
            len = $urandom_range(1, 16);
            repeat (len) step(1'b0, rb);
            $display("rand %0d: btn=%b for %0d level=%b", b, rb, len, btn_level);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage between the raw board push-buttons and the stopwatch control FSM.
- Each of N button inputs gets a two-flop synchronizer and a stable-time debounce filter.
- Per channel, the block produces a clean level, a one-cycle press pulse and a one-cycle release pulse.
- It also produces a single priority-encoded command strobe (lowest index wins), so the stopwatch acts exactly once per physical press.

Parameters:
- N, 4, number of button channels (1..8).
- STABLE_CYCLES, 50000, consecutive cycles the synchronized input must differ from the debounced level before the level flips; must be >= 1.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W >= STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn  input  N  raw asynchronous button levels, 1 = pressed.
- btn_level  output  N  debounced level per channel.
- btn_press  output  N  one-cycle pulse on a debounced 0->1 transition.
- btn_release  output  N  one-cycle pulse on a debounced 1->0 transition.
- cmd_valid  output  1  one-cycle strobe: at least one press occurred this cycle.
- cmd_idx  output  3  index of the lowest-numbered channel in btn_press; held when cmd_valid=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on posedge clk.
- Reset values: sync1, sync2, btn_level, btn_press, btn_release, counters, cmd_valid and cmd_idx are all 0.
- Reset asserted mid-count discards progress. After rst deasserts, a held button needs the full latency again to be recognised.
- Synchronizer: sync1 <= btn; sync2 <= sync1, per channel. No other logic reads btn directly.
- Filter, per channel i, evaluated each cycle:
  - sync2[i] == btn_level[i]: cnt[i] <= 0.
  - sync2[i] != btn_level[i] and cnt[i] == STABLE_CYCLES-1: btn_level[i] <= sync2[i]; cnt[i] <= 0; pulse btn_press[i] if sync2[i]=1, else btn_release[i].
  - Otherwise: cnt[i] <= cnt[i]+1.
- Any bounce back to the old level before the threshold restarts the count from 0. Glitches shorter than STABLE_CYCLES never reach the outputs.
- Latency: btn sampled high at edge E0 and held gives btn_level=1 and btn_press=1 registered at edge E0+STABLE_CYCLES+1, i.e. visible after STABLE_CYCLES+2 edges. Release is symmetric.
- Pulses: btn_press and btn_release are registered, high for exactly one cycle, and coincide with the level change. btn_press[i] and btn_release[i] are never both high.
- Command:
  - cmd_valid <= |press_next, where press_next is the value being registered into btn_press.
  - cmd_idx <= lowest i with press_next[i]=1.
  - cmd_valid and cmd_idx are aligned with btn_press in the same cycle.
  - Simultaneous presses on several channels: all btn_press bits fire, but only the lowest index is reported; there is no queueing.
- Held button: exactly one press pulse, with no auto-repeat. btn_level stays 1 until a qualified release.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Test Plan:
- Clean press, STABLE_CYCLES=8: btn 0->1 at E0, held 20 cycles -> btn_level[0]=1 and btn_press[0]=1 for one cycle at E10; cmd_valid=1, cmd_idx=0 in the same cycle; no further pulses while held.
- Bounce, STABLE_CYCLES=8: btn[2] toggles 1,0,1,0 every 3 cycles, then held high -> no pulse during bouncing; single btn_press[2] 10 edges after the final rising sample; cmd_idx=2.
- Glitch: btn[1] high for 5 cycles, STABLE_CYCLES=8 -> btn_level, btn_press and cmd_valid stay 0 throughout.
- Simultaneous press: btn=4'b1010 on the same edge, held -> btn_press=4'b1010 for one cycle, cmd_valid=1, cmd_idx=1; next cycle cmd_valid=0.
- Release: after a debounced press of ch3, btn[3] returns to 0 -> btn_release[3] one cycle, 10 edges later; btn_level[3]=0; cmd_valid stays 0.
- Reset mid-count: btn[0] held, rst pulsed high for 1 cycle at count 5 -> all outputs 0; btn_press[0] arrives a full STABLE_CYCLES+2 edges after rst deasserts.
